// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader
//  Purpose  : Framed byte-stream loader (count, big-endian words, XOR checksum)
//             that writes instruction memory and releases the CPU from reset
//             once a load finishes cleanly. Macro LOADER_CHECKSUM_EN enables
//             the trailing checksum byte and the CHECK state.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int INSTR_MEM_SIZE = 64,
    parameter int ADDR_WIDTH     = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [8:0] MAX_COUNT = 9'(INSTR_MEM_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           buf_q, buf_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    logic xfer;
    logic last_word;

    assign byte_ready = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign busy       = byte_ready;
    assign done       = (state_q == ST_DONE);
    assign cpu_reset  = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);

    assign mem_write_enable  = we_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = data_q;

    assign xfer      = byte_valid && byte_ready;
    assign last_word = (8'(word_idx_q) == (count_q - 8'd1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_COUNT;
                    word_idx_d = '0;
                    byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            ST_COUNT: begin
                if (xfer) begin
                    if ((byte_in == 8'd0) || ({1'b0, byte_in} > MAX_COUNT)) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = byte_in;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ byte_in;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte goes straight to the write register; the buffer holds only the first three.
                        we_d       = 1'b1;
                        addr_d     = word_idx_q;
                        data_d     = {buf_q, byte_in};
                        word_idx_d = word_idx_q + 1'b1;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end else begin
                        buf_d = {buf_q[15:0], byte_in};
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (byte_in == chk_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_loader
//  Purpose  : Randomized self-checking bench for instr_mem_loader; frames are
//             built and predicted from the stream format, writes are scored
//             from an expected-write queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int MEM = 64;
    localparam int AW  = 6;
`ifdef LOADER_CHECKSUM_EN
    localparam bit HAS_CHK = 1'b1;
`else
    localparam bit HAS_CHK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_address;
    logic [31:0]   mem_write_data;
    logic          cpu_reset, busy, done, error;

    instr_mem_loader #(.INSTR_MEM_SIZE(MEM), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t           exp_q[$];
    logic [31:0]   wbuf[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write scoreboard: strobes must match the expected queue in order and be single-cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_write_enable) begin
                check_eq("strobe_single_cycle", 32'(prev_we), 32'd0);
                check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check_eq("write_addr", 32'(mem_write_address), 32'(w.a));
                    check_eq("write_data", mem_write_data, w.d);
                end
                last_addr = mem_write_address;
                last_data = mem_write_data;
            end else begin
                check_eq("hold_addr", 32'(mem_write_address), 32'(last_addr));
                check_eq("hold_data", mem_write_data, last_data);
            end
            prev_we = mem_write_enable;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_status(input string tag, input bit e_busy, input bit e_done, input bit e_err);
        check_eq({tag, "_busy"},  32'(busy),       32'(e_busy));
        check_eq({tag, "_ready"}, 32'(byte_ready), 32'(e_busy));
        check_eq({tag, "_done"},  32'(done),       32'(e_done));
        check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'(e_done));
        check_eq({tag, "_error"}, 32'(error),      32'(e_err));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        tick();
        exp_q.delete();
        last_addr = '0;
        last_data = '0;
        prev_we   = 1'b0;
        check_status("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset_we",   32'(mem_write_enable), 32'd0);
        check_eq("reset_addr", 32'(mem_write_address), 32'd0);
        check_eq("reset_data", mem_write_data, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_start, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        start      = with_start;
        t = 0;
        while (!byte_ready && t < 50) begin
            tick();
            start = 1'b0;
            t++;
        end
        if (t >= 50) check_eq("handshake_timeout", 32'(t), 32'd0);
        tick();
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic run_load(input int n, input bit bad, input int gap_min, input int gap_max,
                            input int rst_after, input bit start_mid);
        logic [7:0]  bytes[$];
        logic [7:0]  c;
        logic [31:0] word;
        bit          legal;
        bit          e_done;
        wr_t         w;
        legal = (n >= 1) && (n <= MEM);
        c = 8'd0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                word = (i < wbuf.size()) ? wbuf[i] : $urandom;
                for (int b = 0; b < 4; b++) begin
                    bytes.push_back(word[31 - 8*b -: 8]);
                    c = c ^ word[31 - 8*b -: 8];
                end
                if (rst_after < 0 || (i + 1) * 4 <= rst_after) begin
                    w.a = AW'(i);
                    w.d = word;
                    exp_q.push_back(w);
                end
            end
            if (HAS_CHK) bytes.push_back(bad ? (c ^ 8'($urandom_range(1, 255))) : c);
        end
        // Count byte is already valid during the start cycle; it must not be taken then.
        start = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'(n);
        tick();
        start = 1'b0;
        check_status("after_start", 1'b1, 1'b0, 1'b0);
        send_byte(8'(n), 1'b0, 0);
        for (int k = 0; k < bytes.size(); k++) begin
            if (k == rst_after) begin
                check_eq("writes_before_reset", 32'(exp_q.size()), 32'd0);
                do_reset();
                wbuf.delete();
                return;
            end
            send_byte(bytes[k], start_mid && (k == 5), $urandom_range(gap_min, gap_max));
        end
        e_done = legal && !(HAS_CHK && bad);
        check_status("final", 1'b0, e_done, !e_done);
        tick();
        check_eq("writes_pending", 32'(exp_q.size()), 32'd0);
        check_status("final_hold", 1'b0, e_done, !e_done);
        wbuf.delete();
    endtask

    initial begin
        do_reset();

        // Directed frame: two words, good checksum.
        wbuf = '{32'h2001_0005, 32'h0000_0000};
        run_load(2, 1'b0, 0, 0, -1, 1'b0);
        // Same frame with a corrupted checksum.
        wbuf = '{32'h2001_0005, 32'h0000_0000};
        run_load(2, 1'b1, 0, 0, -1, 1'b0);
        // Illegal counts.
        run_load(0, 1'b0, 0, 0, -1, 1'b0);
        run_load(MEM + 1, 1'b0, 0, 0, -1, 1'b0);
        // Byte every other cycle.
        wbuf = '{32'h2001_0005, 32'h0000_0000};
        run_load(2, 1'b0, 1, 1, -1, 1'b0);
        // Reset after three bytes of word 1, then a clean reload.
        wbuf = '{32'h2001_0005, 32'h0000_0000};
        run_load(2, 1'b0, 0, 0, 7, 1'b0);
        wbuf = '{32'h2001_0005, 32'h0000_0000};
        run_load(2, 1'b0, 0, 0, -1, 1'b0);
        // start during DATA is ignored; start after DONE re-arms the loader.
        run_load(3, 1'b0, 0, 1, -1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_status("restart", 1'b1, 1'b0, 1'b0);
        send_byte(8'd0, 1'b0, 0);
        check_status("restart_bad_count", 1'b0, 1'b0, 1'b1);
        // Largest legal frame.
        run_load(MEM, 1'b0, 0, 0, -1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int n;
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(MEM + 1, 255);
                1:       n = 0;
                default: n = $urandom_range(1, 20);
            endcase
            run_load(n, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
